// File: rtl/hazard_forward_unit.sv
// ============================================================================
// hazard_forward_unit
// ----------------------------------------------------------------------------
// Operand forwarding, hazard stall sequencing and event counters for the
// 5-stage MIPS pipeline. Sits beside the ID/EX pipeline registers.
//
// Ports:
//   i_clk, i_reset          pipeline clock, synchronous active-high reset
//   i_instr_rs_D/rt_D       source registers of the instruction in ID
//   i_instr_rs_E/rt_E       source registers of the instruction in EX
//   i_write_reg_E/M/W       destination register in EX / MEM / WB
//   i_reg_write_E/M/W       RegWrite in EX / MEM / WB
//   i_mem_to_reg_E/M        instruction in EX / MEM is a load
//   i_branch_D              instruction in ID is a branch
//   i_halt                  external freeze from the debug unit
//   i_clear_cnt             zero the performance counters
//   o_forward_a/b_FU        ALU operand select  (00 RF, 01 WB, 10 MEM)
//   o_forward_eq_a/b_FU     comparator operand select, same encoding
//   o_stall_F, o_stall_D    hold PC and IF/ID
//   o_flush_E               insert a bubble into ID/EX
//   o_stall_count           saturating count of flush (bubble) cycles
//   o_fwd_count             saturating count of cycles with ALU forwarding
// ============================================================================
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int FORW_EQ    = 2,
    parameter int FORW_ALU   = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [REG_ADDR_W-1:0] i_instr_rs_D,
    input  logic [REG_ADDR_W-1:0] i_instr_rt_D,
    input  logic [REG_ADDR_W-1:0] i_instr_rs_E,
    input  logic [REG_ADDR_W-1:0] i_instr_rt_E,
    input  logic [REG_ADDR_W-1:0] i_write_reg_E,
    input  logic [REG_ADDR_W-1:0] i_write_reg_M,
    input  logic [REG_ADDR_W-1:0] i_write_reg_W,
    input  logic                  i_reg_write_E,
    input  logic                  i_reg_write_M,
    input  logic                  i_reg_write_W,
    input  logic                  i_mem_to_reg_E,
    input  logic                  i_mem_to_reg_M,
    input  logic                  i_branch_D,
    input  logic                  i_halt,
    input  logic                  i_clear_cnt,
    output logic [FORW_ALU-1:0]   o_forward_a_FU,
    output logic [FORW_ALU-1:0]   o_forward_b_FU,
    output logic [FORW_EQ-1:0]    o_forward_eq_a_FU,
    output logic [FORW_EQ-1:0]    o_forward_eq_b_FU,
    output logic                  o_stall_F,
    output logic                  o_stall_D,
    output logic                  o_flush_E,
    output logic [CNT_W-1:0]      o_stall_count,
    output logic [CNT_W-1:0]      o_fwd_count
);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_STALL = 1'b1
    } state_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    // ------------------------------------------------------------------------
    // Forwarding select: MEM beats WB; register 0 is hard-wired and never
    // forwarded even if some stage claims to write it.
    // ------------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] wr_m,
        input logic                  rw_m,
        input logic [REG_ADDR_W-1:0] wr_w,
        input logic                  rw_w
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (src != '0) begin
            if (rw_m && (src == wr_m))
                sel = SEL_MEM;
            else if (rw_w && (src == wr_w))
                sel = SEL_WB;
        end
        return sel;
    endfunction

    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;
    logic [1:0] w_sel_eq_a;
    logic [1:0] w_sel_eq_b;

    assign w_sel_a    = fwd_sel(i_instr_rs_E, i_write_reg_M, i_reg_write_M,
                                i_write_reg_W, i_reg_write_W);
    assign w_sel_b    = fwd_sel(i_instr_rt_E, i_write_reg_M, i_reg_write_M,
                                i_write_reg_W, i_reg_write_W);
    assign w_sel_eq_a = fwd_sel(i_instr_rs_D, i_write_reg_M, i_reg_write_M,
                                i_write_reg_W, i_reg_write_W);
    assign w_sel_eq_b = fwd_sel(i_instr_rt_D, i_write_reg_M, i_reg_write_M,
                                i_write_reg_W, i_reg_write_W);

    // All outputs are forced low while reset is held, including the
    // combinational selects.
    logic [FORW_ALU-1:0] w_fwd_a;
    logic [FORW_ALU-1:0] w_fwd_b;

    assign w_fwd_a           = i_reset ? '0 : FORW_ALU'(w_sel_a);
    assign w_fwd_b           = i_reset ? '0 : FORW_ALU'(w_sel_b);
    assign o_forward_a_FU    = w_fwd_a;
    assign o_forward_b_FU    = w_fwd_b;
    assign o_forward_eq_a_FU = i_reset ? '0 : FORW_EQ'(w_sel_eq_a);
    assign o_forward_eq_b_FU = i_reset ? '0 : FORW_EQ'(w_sel_eq_b);

    // ------------------------------------------------------------------------
    // Hazard detection. A destination of register 0 never creates a
    // dependency, so the EX/MEM hit terms exclude it up front.
    // ------------------------------------------------------------------------
    logic w_hit_E;
    logic w_hit_M;
    logic w_lw_hz;
    logic w_br_alu_hz;
    logic w_br_ld_E;
    logic w_br_ld_M;
    logic [1:0] w_need;

    assign w_hit_E = (i_write_reg_E != '0) &&
                     ((i_write_reg_E == i_instr_rs_D) || (i_write_reg_E == i_instr_rt_D));
    assign w_hit_M = (i_write_reg_M != '0) &&
                     ((i_write_reg_M == i_instr_rs_D) || (i_write_reg_M == i_instr_rt_D));

    assign w_lw_hz     = i_mem_to_reg_E & w_hit_E;
    assign w_br_alu_hz = i_branch_D & i_reg_write_E & ~i_mem_to_reg_E & w_hit_E;
    assign w_br_ld_E   = i_branch_D & w_lw_hz;
    assign w_br_ld_M   = i_branch_D & i_mem_to_reg_M & w_hit_M;

    // Required stall cycles: the maximum over all active hazards.
    assign w_need = w_br_ld_E                            ? 2'd2 :
                    (w_lw_hz | w_br_alu_hz | w_br_ld_M) ? 2'd1 :
                                                           2'd0;

    // ------------------------------------------------------------------------
    // Stall sequencer. A 1-cycle need is served entirely in RUN; a 2-cycle
    // need spends its second cycle in STALL, where cnt counts the cycles
    // still owed after the current one plus one (exits when cnt == 1).
    // ------------------------------------------------------------------------
    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_cnt;
    logic [1:0] w_next_cnt;
    logic       w_stall;
    logic       w_flush;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_stall      = 1'b0;
        w_flush      = 1'b0;
        if (i_reset) begin
            w_next_state = S_RUN;
            w_next_cnt   = 2'd0;
        end else if (i_halt) begin
            // Freeze the front end without injecting bubbles; the sequence
            // picks up where it stopped once halt drops.
            w_stall = 1'b1;
        end else begin
            unique case (r_state)
                S_RUN: begin
                    if (w_need != 2'd0) begin
                        w_stall = 1'b1;
                        w_flush = 1'b1;
                    end
                    if (w_need == 2'd2) begin
                        w_next_state = S_STALL;
                        w_next_cnt   = 2'd1;
                    end
                end
                S_STALL: begin
                    w_stall    = 1'b1;
                    w_flush    = 1'b1;
                    w_next_cnt = r_cnt - 2'd1;
                    // cnt == 0 is unreachable; treat it as done for safety.
                    if (r_cnt <= 2'd1) begin
                        w_next_state = S_RUN;
                        w_next_cnt   = 2'd0;
                    end
                end
                default: begin
                    w_next_state = S_RUN;
                    w_next_cnt   = 2'd0;
                end
            endcase
        end
    end

    assign o_stall_F = w_stall;
    assign o_stall_D = w_stall;
    assign o_flush_E = w_flush;

    // ------------------------------------------------------------------------
    // Saturating event counters. Clear has priority over an increment in the
    // same cycle.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_fwd_count;
    logic             w_fwd_evt;

    assign w_fwd_evt = (w_fwd_a != '0) || (w_fwd_b != '0);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear_cnt) begin
            r_stall_count <= '0;
            r_fwd_count   <= '0;
        end else begin
            if (w_flush && (r_stall_count != {CNT_W{1'b1}}))
                r_stall_count <= r_stall_count + 1'b1;
            if (w_fwd_evt && (r_fwd_count != {CNT_W{1'b1}}))
                r_fwd_count <= r_fwd_count + 1'b1;
        end
    end

    assign o_stall_count = r_stall_count;
    assign o_fwd_count   = r_fwd_count;

endmodule
